// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope capture buffer.
package scope_pkg;

  localparam int DEPTH_DEF = 640;
  localparam int SW_DEF    = 12;
  localparam int ADDR_W    = $clog2(DEPTH_DEF);

  typedef logic signed [SW_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/scope_sample_ram.sv
// Frame store: one synchronous write port, one registered read port.
// Out-of-range read addresses return zero.
module scope_sample_ram
  import scope_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int SW    = 12
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [SW-1:0]     i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [SW-1:0]     o_rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SW-1:0] r_mem [DEPTH];
  logic [SW-1:0] r_rdata;
  logic [IW-1:0] w_widx;
  logic [IW-1:0] w_ridx;
  logic          w_wInRange;
  logic          w_rInRange;

  assign w_widx     = i_waddr[IW-1:0];
  assign w_ridx     = i_raddr[IW-1:0];
  assign w_wInRange = (32'(i_waddr) < DEPTH);
  assign w_rInRange = (32'(i_raddr) < DEPTH);

  always_ff @(posedge i_clock) begin
    if (i_we && w_wInRange) begin
      r_mem[w_widx] <= i_wdata;
    end
  end

  // Read-before-write: a same-cycle write is seen on the following read.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_rdata <= '0;
    end else if (w_rInRange) begin
      r_rdata <= r_mem[w_ridx];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/scope_capture_buffer.sv
// Triggered capture stage: decimates the sample stream, waits for a level/slope
// trigger or auto-timeout, stores one frame and holds it until the renderer acks.
module scope_capture_buffer
  import scope_pkg::*;
#(
  parameter int DEPTH   = 640,
  parameter int SW      = 12,
  parameter int DEC_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                 i_clock,
  input  logic                 i_resetn,
  input  logic signed [SW-1:0] i_sample_in,
  input  logic                 i_sample_valid,
  input  logic                 i_run,
  input  logic                 i_auto_en,
  input  logic                 i_trig_slope,
  input  logic signed [SW-1:0] i_trig_level,
  input  logic [DEC_W-1:0]     i_decim,
  input  logic                 i_frame_ack,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [SW-1:0]        o_rd_data,
  output logic                 o_frame_ready,
  output logic                 o_capturing,
  output logic                 o_auto_trig
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                r_state;
  logic [DEC_W-1:0]      r_decCnt;
  logic signed [SW-1:0]  r_prev;
  logic                  r_prevOk;
  logic [TO_W-1:0]       r_toCnt;
  logic [ADDR_W-1:0]     r_waddr;
  logic                  r_frameReady;
  logic                  r_capturing;
  logic                  r_autoTrig;

  logic                  w_accept;
  logic                  w_enterArmed;
  logic                  w_realTrig;
  logic                  w_autoTrig;
  logic                  w_trig;
  logic                  w_we;
  logic                  w_lastWrite;
  logic [ADDR_W-1:0]     w_waddr;

  assign w_accept     = i_sample_valid && (r_decCnt == '0);
  assign w_enterArmed = i_run && ((r_state == ST_IDLE) ||
                                  ((r_state == ST_HOLD) && i_frame_ack));

  always_comb begin
    w_realTrig = 1'b0;
    if (r_prevOk) begin
      if (i_trig_slope) begin
        w_realTrig = (r_prev > i_trig_level) && (i_sample_in <= i_trig_level);
      end else begin
        w_realTrig = (r_prev < i_trig_level) && (i_sample_in >= i_trig_level);
      end
    end
  end

  assign w_autoTrig  = i_auto_en && (r_toCnt == TO_W'(TIMEOUT - 1));
  assign w_trig      = i_run && (r_state == ST_ARMED) && w_accept && (w_realTrig || w_autoTrig);
  assign w_we        = w_trig || (i_run && (r_state == ST_CAPTURE) && w_accept);
  assign w_waddr     = (r_state == ST_ARMED) ? '0 : r_waddr;
  assign w_lastWrite = (r_waddr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_decCnt <= '0;
    end else if (w_enterArmed) begin
      r_decCnt <= '0;
    end else if (w_accept) begin
      r_decCnt <= i_decim;
    end else if (i_sample_valid) begin
      r_decCnt <= r_decCnt - 1'b1;
    end
  end

  // prev_ok gates the slope test so the first sample after arming never fires.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_prev   <= '0;
      r_prevOk <= 1'b0;
    end else begin
      if (w_accept) begin
        r_prev <= i_sample_in;
      end
      if (w_enterArmed) begin
        r_prevOk <= 1'b0;
      end else if (w_accept) begin
        r_prevOk <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_toCnt <= '0;
    end else if (w_enterArmed) begin
      r_toCnt <= '0;
    end else if ((r_state == ST_ARMED) && w_accept && (r_toCnt != TO_W'(TIMEOUT - 1))) begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= ST_IDLE;
      r_waddr      <= '0;
      r_frameReady <= 1'b0;
      r_capturing  <= 1'b0;
      r_autoTrig   <= 1'b0;
    end else if (!i_run) begin
      r_state      <= ST_IDLE;
      r_frameReady <= 1'b0;
      r_capturing  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (w_trig) begin
            r_state     <= ST_CAPTURE;
            r_capturing <= 1'b1;
            r_autoTrig  <= !w_realTrig;
            r_waddr     <= ADDR_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (w_accept) begin
            if (w_lastWrite) begin
              r_state      <= ST_HOLD;
              r_capturing  <= 1'b0;
              r_frameReady <= 1'b1;
            end else begin
              r_waddr <= r_waddr + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (i_frame_ack) begin
            r_state      <= ST_ARMED;
            r_frameReady <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  scope_sample_ram #(
    .DEPTH(DEPTH),
    .SW   (SW)
  ) u_ram (
    .i_clock (i_clock),
    .i_resetn(i_resetn),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (i_sample_in),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );

  assign o_frame_ready = r_frameReady;
  assign o_capturing   = r_capturing;
  assign o_auto_trig   = r_autoTrig;

endmodule

// File: doc/scope_capture_buffer.md
# scope_capture_buffer

Triggered oscilloscope capture stage between the waveform-select mux and the VGA renderer. Takes the selected signed 12-bit sample stream, decimates it, waits for a level/slope trigger (or an auto-timeout), and stores one screen-width frame. The frame is held for the VGA side to read through a synchronous port until it acknowledges, so the trace is stable and phase-locked across frames.

## Interface
- DEPTH, 640: samples per frame (one per horizontal pixel)
- SW, 12: sample width, signed two's complement
- DEC_W, 8: decimation control width
- TIMEOUT, 4096: accepted samples without a trigger before auto-trigger
- clock  in  1  single clock for all logic
- resetn  in  1  asynchronous, active-low reset
- sample_in  in  SW  signed sample from the waveform mux
- sample_valid  in  1  sample_in valid this cycle
- run  in  1  1 = capture enabled; 0 = abort to IDLE
- auto_en  in  1  enable timeout auto-trigger
- trig_slope  in  1  0 = rising, 1 = falling
- trig_level  in  SW  signed trigger threshold
- decim  in  DEC_W  keep 1 of every decim+1 valid samples
- frame_ack  in  1  one-cycle pulse from renderer: frame consumed
- rd_addr  in  10  renderer read address
- rd_data  out  SW  stored sample, 1-cycle read latency
- frame_ready  out  1  complete frame held and readable
- capturing  out  1  high in CAPTURE
- auto_trig  out  1  current/last frame was started by timeout

## Operation
- States: IDLE, ARMED, CAPTURE, HOLD.
- IDLE: run=1 -> ARMED. ARMED: trigger -> CAPTURE. CAPTURE: write of address DEPTH-1 -> HOLD. HOLD: frame_ack -> ARMED.
- run=0 in any state -> IDLE on next edge; wins over frame_ack and trigger in the same cycle.
- Decimator: counter dec_cnt counts only on sample_valid; sample accepted when dec_cnt==0, then reload with decim. Cleared to 0 on entering ARMED. decim change takes effect at next reload. decim=0 accepts every valid sample.
- Trigger (ARMED only, accepted samples only, signed compare): rising = prev < trig_level and cur >= trig_level; falling = prev > trig_level and cur <= trig_level. prev register updated on every accepted sample; prev_ok flag cleared on entering ARMED, so the first accepted sample after arming never triggers.
- Timeout: in ARMED, count accepted samples; when auto_en=1 and count reaches TIMEOUT-1 on an accepted sample, that sample forces the trigger and auto_trig=1. Real trigger sets auto_trig=0. Count cleared on entering ARMED.
- The triggering sample is written to address 0; subsequent accepted samples to 1..DEPTH-1. Write address does not wrap; no writes outside CAPTURE.
- HOLD: RAM frozen; further samples ignored.
- Read: rd_data registered from RAM at rd_addr every cycle regardless of state; rd_addr >= DEPTH returns 0. Reads during CAPTURE return partial/old data (renderer gates on frame_ready).
- frame_ack outside HOLD ignored.

## Timing
- Reset values: rd_data=0, frame_ready=0, capturing=0, auto_trig=0, state IDLE, all counters 0. RAM contents not cleared.
- Trigger sample accepted at edge N: capturing=1 after edge N, address 0 written at edge N.
- Edge writing address DEPTH-1 sets frame_ready=1 and capturing=0 simultaneously.
- frame_ack sampled at edge M: frame_ready=0 after edge M, state ARMED.
- rd_addr presented before edge K -> rd_data valid after edge K.
- Reset mid-capture: immediate return to reset values; next frame needs run and a fresh trigger.

## Structure
- Package scope_pkg: state enum, address width constant (clog2 of DEPTH), signed sample typedef.
- Sub-module scope_sample_ram: single-port-write / single-port-read synchronous RAM, DEPTH x SW, registered read with out-of-range zero.
- Trigger detect, decimator, timeout counter and FSM in the top block.

## Test plan
- DEPTH=16, decim=0, level=0, rising, ramp -8..+7 repeated -> first write at sample value 0, frame holds 0..7,-8..-1, frame_ready after 16 accepted samples.
- decim=3, same ramp -> every 4th valid sample stored; sample_valid gaps do not advance dec_cnt.
- Falling slope, level=100, sine amplitude 1000 -> address 0 value <= 100 with previous accepted > 100; auto_trig=0.
- Constant input 50, auto_en=1, TIMEOUT=32 -> capture starts on 32nd accepted sample, auto_trig=1; auto_en=0 -> never triggers.
- HOLD then frame_ack pulse -> frame_ready falls next edge, RAM unchanged until next trigger; run=0 with simultaneous ack -> IDLE.
- resetn low mid-CAPTURE -> all outputs 0 asynchronously; rd_addr=700 -> rd_data=0.
